// File: rtl/pipe_mdu_ctrl.sv
// Iterative multiply/divide sequencer next to the EXE-stage ALU.
// It owns HI/LO, serves MFHI/MFLO/MTHI/MTLO and stalls the pipeline while busy.
module pipe_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             evalid,
    input  logic [3:0]       emdop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    output logic             mdu_stall,
    output logic             mdu_busy,
    output logic [WIDTH-1:0] mdu_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, SIGNFIX} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]     p_reg, p_next;
    logic [WIDTH-1:0]       b_reg, b_next;
    logic [WIDTH-1:0]       ea_reg, ea_next;
    logic                   is_div_reg, is_div_next;
    logic                   neg_q_reg, neg_q_next;
    logic                   neg_r_reg, neg_r_next;
    logic [WIDTH-1:0]       hi_reg, hi_next;
    logic [WIDTH-1:0]       lo_reg, lo_next;

    logic                   op_signed;
    logic [WIDTH-1:0]       ea_abs, eb_abs;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       q_fix, r_fix;

    assign op_signed = (emdop == OP_MULT) || (emdop == OP_DIV);
    assign ea_abs    = (op_signed && ea[WIDTH-1]) ? -ea : ea;
    assign eb_abs    = (op_signed && eb[WIDTH-1]) ? -eb : eb;

    // Multiply: p = {partial, multiplier}; add b into the top half when the
    // multiplier LSB is set, then shift the whole thing right by one.
    assign mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, b_reg} : '0);

    // Restoring divide: p = {remainder, dividend/quotient}.
    assign div_shift = {p_reg[2*WIDTH-1:WIDTH], p_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_reg};
    assign div_diff  = div_shift[WIDTH-1:0] - b_reg;

    assign prod_fix  = neg_q_reg ? -p_reg : p_reg;
    assign q_fix     = neg_q_reg ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
    assign r_fix     = neg_r_reg ? -p_reg[2*WIDTH-1:WIDTH] : p_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        p_next      = p_reg;
        b_next      = b_reg;
        ea_next     = ea_reg;
        is_div_next = is_div_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        case (state_reg)
            IDLE: begin
                if (evalid && (emdop == OP_MULT || emdop == OP_MULTU)) begin
                    state_next  = CALC;
                    cnt_next    = '0;
                    p_next      = {{WIDTH{1'b0}}, eb_abs};
                    b_next      = ea_abs;
                    ea_next     = ea;
                    is_div_next = 1'b0;
                    neg_q_next  = op_signed && (ea[WIDTH-1] ^ eb[WIDTH-1]);
                    neg_r_next  = 1'b0;
                end else if (evalid && (emdop == OP_DIV || emdop == OP_DIVU)) begin
                    state_next  = CALC;
                    cnt_next    = '0;
                    p_next      = {{WIDTH{1'b0}}, ea_abs};
                    b_next      = eb_abs;
                    ea_next     = ea;
                    is_div_next = 1'b1;
                    neg_q_next  = op_signed && (ea[WIDTH-1] ^ eb[WIDTH-1]);
                    neg_r_next  = op_signed && ea[WIDTH-1];
                end else if (evalid && emdop == OP_MTHI) begin
                    hi_next = ea;
                end else if (evalid && emdop == OP_MTLO) begin
                    lo_next = ea;
                end
            end
            CALC: begin
                if (is_div_reg)
                    p_next = div_ge ? {div_diff, p_reg[WIDTH-2:0], 1'b1}
                                    : {div_shift[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0};
                else
                    p_next = {mul_sum, p_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(WIDTH-1))
                    state_next = SIGNFIX;
            end
            SIGNFIX: begin
                state_next = IDLE;
                if (is_div_reg && b_reg == '0) begin
                    lo_next = '1;
                    hi_next = ea_reg;
                end else if (is_div_reg) begin
                    lo_next = q_fix;
                    hi_next = r_fix;
                end else begin
                    {hi_next, lo_next} = prod_fix;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            p_reg      <= '0;
            b_reg      <= '0;
            ea_reg     <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            p_reg      <= p_next;
            b_reg      <= b_next;
            ea_reg     <= ea_next;
            is_div_reg <= is_div_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    assign mdu_busy  = (state_reg != IDLE);
    assign mdu_stall = evalid && (emdop >= OP_MULT) && (emdop <= OP_MTLO) && mdu_busy;
    assign div_zero  = (state_reg == SIGNFIX) && is_div_reg && (b_reg == '0);
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    always_comb begin
        mdu_out = '0;
        if (emdop == OP_MFHI)
            mdu_out = hi_reg;
        else if (emdop == OP_MFLO)
            mdu_out = lo_reg;
    end

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Directed bench for pipe_mdu_ctrl: vector table of MUL/DIV ops plus
// hand-written sequences for MTHI/MFHI, stall behaviour and mid-op reset.
module tb_pipe_mdu_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        evalid = 1'b0;
    logic [3:0]  emdop = 4'd0;
    logic [31:0] ea = '0;
    logic [31:0] eb = '0;
    logic        mdu_stall, mdu_busy, div_zero;
    logic [31:0] mdu_out, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pipe_mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .evalid(evalid), .emdop(emdop),
        .ea(ea), .eb(eb), .mdu_stall(mdu_stall), .mdu_busy(mdu_busy),
        .mdu_out(mdu_out), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue in cycle 0, then observe cycles 1..33 and the result in cycle 34.
    task automatic run_op(input vec_t v);
        int busy_bad;
        int dz_bad;
        busy_bad = 0;
        dz_bad   = 0;
        @(negedge clock);
        evalid = 1'b1; emdop = v.op; ea = v.a; eb = v.b;
        #1 check({v.name, " self-stall"}, {31'd0, mdu_stall}, 32'd0);
        @(negedge clock);
        evalid = 1'b0; emdop = 4'd0;
        for (int k = 1; k <= 33; k++) begin
            if (mdu_busy !== 1'b1) busy_bad++;
            if (div_zero !== ((k == 33) ? v.exp_dz : 1'b0)) dz_bad++;
            @(negedge clock);
        end
        check({v.name, " busy 1..33 bad cycles"}, 32'(busy_bad), 32'd0);
        check({v.name, " div_zero pattern bad cycles"}, 32'(dz_bad), 32'd0);
        check({v.name, " busy c34"}, {31'd0, mdu_busy}, 32'd0);
        check({v.name, " hi"}, hi, v.exp_hi);
        check({v.name, " lo"}, lo, v.exp_lo);
        $display("op %-22s a=%08h b=%08h -> hi=%08h lo=%08h", v.name, v.a, v.b, hi, lo);
    endtask

    initial begin
        int stall_bad;
        vecs[0] = '{"MULT -3*7",          4'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1] = '{"MULTU max*max",      4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2] = '{"DIV -7/2",           4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3] = '{"DIVU 7/2",           4'd4, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[4] = '{"DIV min/-1",         4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[5] = '{"DIVU 5/0",           4'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[6] = '{"DIV 7/-2",           4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[7] = '{"DIV -5/0",           4'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[8] = '{"MULT -5*-6",         4'd1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30,       1'b0};
        vecs[9] = '{"MULTU 2^16*2^16",    4'd2, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset busy", {31'd0, mdu_busy}, 32'd0);
        check("reset stall", {31'd0, mdu_stall}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // MTHI / MFHI and MTLO / MFLO back to back
        @(negedge clock);
        evalid = 1'b1; emdop = 4'd7; ea = 32'h1234;
        #1 check("MTHI stall", {31'd0, mdu_stall}, 32'd0);
        @(negedge clock);
        emdop = 4'd5;
        #1 check("MFHI out", mdu_out, 32'h1234);
        check("MFHI stall", {31'd0, mdu_stall}, 32'd0);
        @(negedge clock);
        emdop = 4'd8; ea = 32'h5678;
        @(negedge clock);
        emdop = 4'd6;
        #1 check("MFLO out", mdu_out, 32'h5678);
        emdop = 4'd0;
        #1 check("none op out", mdu_out, 32'd0);
        $display("mt/mf seq hi=%08h lo=%08h", hi, lo);

        // DIV 100/7 followed by an MFLO stalled until the result lands
        @(negedge clock);
        evalid = 1'b1; emdop = 4'd3; ea = 32'd100; eb = 32'd7;
        @(negedge clock);
        stall_bad = 0;
        for (int k = 1; k <= 33; k++) begin
            evalid = 1'b1;
            emdop  = (k == 10) ? 4'd0 : (k == 11) ? 4'd9 : (k == 12) ? 4'd1 : 4'd6;
            if (k == 12) evalid = 1'b0;
            #1;
            if (mdu_stall !== ((k >= 10 && k <= 12) ? 1'b0 : 1'b1)) stall_bad++;
            @(negedge clock);
        end
        check("MFLO stall pattern bad cycles", 32'(stall_bad), 32'd0);
        evalid = 1'b1; emdop = 4'd6;
        #1 check("MFLO c34 stall", {31'd0, mdu_stall}, 32'd0);
        check("MFLO c34 out", mdu_out, 32'd14);
        check("DIV 100/7 hi", hi, 32'd2);
        @(negedge clock);
        evalid = 1'b0; emdop = 4'd1;
        @(negedge clock);
        check("idle after MFLO and bubble", {31'd0, mdu_busy}, 32'd0);
        emdop = 4'd0;
        $display("stall seq lo=%08h hi=%08h", lo, hi);

        // Reset during CALC
        @(negedge clock);
        evalid = 1'b1; emdop = 4'd2; ea = 32'd3; eb = 32'd5;
        @(negedge clock);
        evalid = 1'b0; emdop = 4'd0;
        repeat (10) @(negedge clock);
        reset = 1'b1; evalid = 1'b1; emdop = 4'd6;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post-reset busy", {31'd0, mdu_busy}, 32'd0);
        check("post-reset stall", {31'd0, mdu_stall}, 32'd0);
        check("post-reset hi", hi, 32'd0);
        check("post-reset lo", lo, 32'd0);
        $display("mid-op reset hi=%08h lo=%08h", hi, lo);
        evalid = 1'b0; emdop = 4'd0;
        run_op('{"MULTU 6*7 after reset", 4'd2, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
